// File: rtl/log_axi_reader.sv
// log_axi_reader: single-outstanding AXI4-Lite read master for the log accesser.
// Optional timeout/drain path enabled by defining LOG_AXI_READER_TIMEOUT_EN.
module log_axi_reader #(
    parameter logic [31:0] LOG_BASE_ADDR  = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_mem_addr,
    input  logic        i_read_trigger,
    output logic [31:0] o_mem_value,
    output logic        o_done,
    output logic        o_error,
    output logic        o_busy,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

    state_t      state;
    state_t      state_nx;
    logic        load;
    logic        fin;
    logic        fin_err;
    logic [31:0] fin_data;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..65535");
    end

    assign m_axi_arprot = 3'b000;
    assign o_busy       = (state != IDLE);

`ifdef LOG_AXI_READER_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        ar_pend;
    logic        expire;

    assign expire = ((17'(to_cnt) + 17'd1) == 17'(TIMEOUT_CYCLES));

    // Timeout counter runs only while waiting on the slave.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (load) begin
            to_cnt <= '0;
        end else if (state == ADDR || state == DATA) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    // Tracks an AR still owed to the slave so DRAIN can finish it first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_pend <= 1'b0;
        end else if (load) begin
            ar_pend <= 1'b1;
        end else if (m_axi_arvalid && m_axi_arready) begin
            ar_pend <= 1'b0;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, handshake outputs and completion decode.
    always_comb begin
        state_nx      = state;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        load          = 1'b0;
        fin           = 1'b0;
        fin_err       = 1'b0;
        fin_data      = '0;
        unique case (state)
            IDLE: begin
                if (i_read_trigger) begin
                    load     = 1'b1;
                    state_nx = ADDR;
                end
            end
            ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    fin      = 1'b1;
                    state_nx = IDLE;
                    if (m_axi_rresp inside {2'b10, 2'b11}) begin
                        fin_err = 1'b1;
                    end else begin
                        fin_data = m_axi_rdata;
                    end
                end
            end
            DRAIN: begin
`ifdef LOG_AXI_READER_TIMEOUT_EN
                m_axi_arvalid = ar_pend;
                m_axi_rready  = !ar_pend;
                if (!ar_pend && m_axi_rvalid) begin
                    state_nx = IDLE;
                end
`else
                state_nx = IDLE;
`endif
            end
        endcase
`ifdef LOG_AXI_READER_TIMEOUT_EN
        // A beat landing on the expiry cycle completes normally.
        if ((state == ADDR || (state == DATA && !m_axi_rvalid)) && expire) begin
            fin      = 1'b1;
            fin_err  = 1'b1;
            fin_data = '0;
            state_nx = DRAIN;
        end
`endif
    end

    // Registered result, pulses and latched read address.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_mem_value  <= '0;
            m_axi_araddr <= '0;
        end else begin
            o_done  <= fin;
            o_error <= fin_err;
            if (fin) begin
                o_mem_value <= fin_data;
            end
            if (load) begin
                m_axi_araddr <= LOG_BASE_ADDR + {i_mem_addr[29:0], 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_log_axi_reader.sv
// tb_log_axi_reader: randomized self-checking bench for log_axi_reader.
// Timeout scenarios run only when LOG_AXI_READER_TIMEOUT_EN is defined.
module tb_log_axi_reader;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          TO   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic        trig;
    logic [31:0] mem_value;
    logic        done;
    logic        error;
    logic        busy;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    log_axi_reader #(
        .LOG_BASE_ADDR (BASE),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_mem_addr    (mem_addr),
        .i_read_trigger(trig),
        .o_mem_value   (mem_value),
        .o_done        (done),
        .o_error       (error),
        .o_busy        (busy),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    // One read: AR ready after ard cycles, R valid after rd cycles.
    task automatic run_txn(input logic [31:0] idx, input int ard, input int rd,
                           input logic [31:0] data, input logic [1:0] resp,
                           input bit pre, input bit stray, input bit early_r,
                           input bit chain, input logic [31:0] next_idx,
                           input string name);
        logic [31:0] exp_addr;
        logic [31:0] exp_val;
        logic        exp_err;
        int          exp_lat;
        int          phase = 0;
        int          wc = 0;
        int          k;
        bit          fin = 0;
        exp_addr = BASE + (idx * 32'd4);
        exp_err  = (resp >= 2'd2);
        exp_val  = exp_err ? 32'd0 : data;
        exp_lat  = 3 + ard + rd;
        if (!pre) begin
            @(negedge clk);
            trig = 1'b1;
            mem_addr = idx;
        end
        @(negedge clk);
        trig = 1'b0;
        k = 1;
        while (!fin && k < 200) begin
            case (phase)
                0: begin
                    checks++;
                    if ({arvalid, rready, busy, done} !== 4'b1010) begin
                        failures++;
                        $display("FAIL %s addr_ctrl k=%0d got %b want 1010",
                                 name, k, {arvalid, rready, busy, done});
                    end
                    checks++;
                    if (araddr !== exp_addr) begin
                        failures++;
                        $display("FAIL %s araddr k=%0d got %h want %h",
                                 name, k, araddr, exp_addr);
                    end
                    arready = (wc >= ard);
                    rvalid  = early_r;
                    rdata   = $urandom;
                    if (arready) begin
                        phase = 1;
                        wc = 0;
                    end else begin
                        wc++;
                    end
                end
                1: begin
                    checks++;
                    if ({arvalid, rready, busy, done} !== 4'b0110) begin
                        failures++;
                        $display("FAIL %s data_ctrl k=%0d got %b want 0110",
                                 name, k, {arvalid, rready, busy, done});
                    end
                    trig     = stray && (wc == 0);
                    mem_addr = 32'd5;
                    arready  = 1'b0;
                    rvalid   = (wc >= rd);
                    rdata    = rvalid ? data : $urandom;
                    rresp    = resp;
                    if (rvalid) phase = 2;
                    else wc++;
                end
                default: begin
                    rvalid = 1'b0;
                    trig   = 1'b0;
                    checks++;
                    if ({done, error, busy} !== {1'b1, exp_err, 1'b0}) begin
                        failures++;
                        $display("FAIL %s done_flags got %b want %b",
                                 name, {done, error, busy}, {1'b1, exp_err, 1'b0});
                    end
                    checks++;
                    if (mem_value !== exp_val) begin
                        failures++;
                        $display("FAIL %s value got %h want %h",
                                 name, mem_value, exp_val);
                    end
                    checks++;
                    if (k != exp_lat) begin
                        failures++;
                        $display("FAIL %s latency got %0d want %0d",
                                 name, k, exp_lat);
                    end
                    fin = 1;
                    if (chain) begin
                        trig = 1'b1;
                        mem_addr = next_idx;
                    end
                end
            endcase
            if (!fin) begin
                @(negedge clk);
                k++;
            end
        end
        if (!fin) begin
            failures++;
            $display("FAIL %s no_completion got none want done", name);
            arready = 1'b0;
            rvalid = 1'b0;
            trig = 1'b0;
        end else if (!chain) begin
            @(negedge clk);
            checks++;
            if ({done, busy, arvalid} !== 3'b000) begin
                failures++;
                $display("FAIL %s after_done got %b want 000",
                         name, {done, busy, arvalid});
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        trig = 1'b0;
        mem_addr = '0;
        arready = 1'b0;
        rvalid = 1'b0;
        rdata = '0;
        rresp = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({done, error, busy, arvalid, rready} !== 5'b0 ||
            mem_value !== 32'd0 || araddr !== 32'd0 || arprot !== 3'd0) begin
            failures++;
            $display("FAIL reset_values got %b/%h/%h/%b want 0/0/0/0",
                     {done, error, busy, arvalid, rready}, mem_value, araddr, arprot);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, busy, arvalid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle got %b want 000", {done, busy, arvalid});
        end
    endtask

    task automatic test_directed();
        run_txn(32'd4, 0, 0, 32'h0000_00FF, 2'b00, 0, 0, 0, 0, 0, "zero_wait");
        run_txn(32'd8, 5, 3, $urandom, 2'b01, 0, 0, 1, 0, 0, "delayed");
        run_txn(32'd2, 1, 0, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 0, 0, "slverr");
        run_txn(32'd3, 0, 2, 32'hDEAD_BEEF, 2'b11, 0, 0, 0, 0, 0, "decerr");
        run_txn(32'hFFFF_FFFF, 0, 0, 32'h1234_5678, 2'b00, 0, 0, 0, 0, 0, "wrap");
    endtask

    task automatic test_stray_trigger();
        run_txn(32'd9, 1, 2, 32'hCAFE_0001, 2'b00, 0, 1, 0, 0, 0, "stray");
        run_txn(32'd5, 0, 0, 32'hCAFE_0002, 2'b00, 0, 0, 0, 0, 0, "after_stray");
    endtask

    task automatic test_back_to_back();
        run_txn(32'd10, 0, 0, 32'hA5A5_0001, 2'b00, 0, 0, 0, 1, 32'd11, "b2b_first");
        run_txn(32'd11, 2, 1, 32'hA5A5_0002, 2'b00, 1, 0, 0, 0, 0, "b2b_second");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_txn($urandom, $urandom_range(0, 6), $urandom_range(0, 6), $urandom,
                    2'($urandom_range(0, 3)), 0, 0, 1'($urandom_range(0, 1)),
                    0, 0, "random");
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        trig = 1'b1;
        mem_addr = 32'd7;
        @(negedge clk);
        trig = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        checks++;
        if ({arvalid, rready, busy} !== 3'b011) begin
            failures++;
            $display("FAIL mid_reset_in_data got %b want 011", {arvalid, rready, busy});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({arvalid, rready, busy, done, error} !== 5'b0 || mem_value !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_state got %b/%h want 00000/0",
                     {arvalid, rready, busy, done, error}, mem_value);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset_quiet got %b want 00", {busy, done});
        end
        run_txn(32'd6, 1, 1, 32'h0BAD_F00D, 2'b00, 0, 0, 0, 0, 0, "post_reset");
    endtask

`ifdef LOG_AXI_READER_TIMEOUT_EN
    task automatic test_timeout();
        int dones = 0;
        int bad_ar = 0;
        @(negedge clk);
        trig = 1'b1;
        mem_addr = 32'd12;
        @(negedge clk);
        trig = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            if (done) dones++;
            if (k <= 41 && arvalid !== 1'b1) bad_ar++;
            if (k == 17) begin
                checks++;
                if ({done, error, busy, arvalid} !== 4'b1111 || mem_value !== 32'd0) begin
                    failures++;
                    $display("FAIL timeout_pulse got %b/%h want 1111/0",
                             {done, error, busy, arvalid}, mem_value);
                end
            end
            if (k == 42) begin
                checks++;
                if ({arvalid, rready, busy} !== 3'b011) begin
                    failures++;
                    $display("FAIL drain_rready got %b want 011", {arvalid, rready, busy});
                end
            end
            if (k == 43) begin
                checks++;
                if ({busy, done} !== 2'b00) begin
                    failures++;
                    $display("FAIL drain_exit got %b want 00", {busy, done});
                end
            end
            arready = (k == 41);
            rvalid  = (k == 42);
            rdata   = 32'hFEED_FACE;
            rresp   = 2'b00;
            @(negedge clk);
        end
        checks++;
        if (dones != 1 || bad_ar != 0) begin
            failures++;
            $display("FAIL timeout_once got dones=%0d arvalid_drops=%0d want 1/0",
                     dones, bad_ar);
        end
        run_txn(32'd13, 0, 14, 32'h5151_0000, 2'b00, 0, 0, 0, 0, 0, "expiry_race");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_stray_trigger();
        test_back_to_back();
        test_random();
        test_mid_reset();
`ifdef LOG_AXI_READER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/log_axi_reader.md
# log_axi_reader

Single-outstanding AXI4-Lite read master that services the memory-read port of the log accesser. It turns a one-cycle read trigger plus a word index into one AR/R transaction against the shared-memory log region. It returns the 32-bit word with a done pulse, or an error pulse on a bad response or timeout. It sits directly between the log accesser's `o_mem_addr`/`o_read_trigger` outputs and the system AXI interconnect.

## Interface

Parameters:
- `LOG_BASE_ADDR`, default 32'h0000_0000: byte base address of the log region.
- `TIMEOUT_CYCLES`, default 256: cycles allowed from AR issue to R handshake; valid range 2..65535.

Ports:
- `clk` in, 1 bit: single clock for all logic.
- `rst` in, 1 bit: synchronous, active-high reset.
- `i_mem_addr` in, 32 bits: word index into the log region, sampled on an accepted trigger.
- `i_read_trigger` in, 1 bit: one-cycle read request pulse.
- `o_mem_value` out, 32 bits: read data; valid when `o_done`=1 and held until the next completion.
- `o_done` out, 1 bit: one-cycle completion pulse, asserted for both success and error.
- `o_error` out, 1 bit: asserted together with `o_done` when the read failed.
- `o_busy` out, 1 bit: high in every state except IDLE.
- `m_axi_araddr` out, 32 bits: read address.
- `m_axi_arprot` out, 3 bits: constant 3'b000.
- `m_axi_arvalid` out, 1 bit.
- `m_axi_arready` in, 1 bit.
- `m_axi_rdata` in, 32 bits.
- `m_axi_rresp` in, 2 bits.
- `m_axi_rvalid` in, 1 bit.
- `m_axi_rready` out, 1 bit.

## Operation

- States: IDLE, ADDR, DATA, DRAIN.
- **IDLE**
  - If `i_read_trigger`=1: latch `m_axi_araddr` = `LOG_BASE_ADDR` + (`i_mem_addr` << 2), modulo 2^32 (wrap, no error).
  - Clear the timeout counter and go to ADDR.
- **ADDR**
  - `m_axi_arvalid`=1 and `araddr` held stable.
  - On `arvalid`&`arready`: go to DATA.
- **DATA**
  - `m_axi_rready`=1.
  - On `rvalid`&`rready`:
    - If `rresp` is OKAY (0) or EXOKAY (1): register `o_mem_value`=`rdata`, pulse `o_done`, `o_error`=0.
    - If `rresp` is SLVERR (2) or DECERR (3): `o_mem_value`=0, pulse `o_done` and `o_error`.
  - Return to IDLE.
- **DRAIN** (timeout build only)
  - `arvalid`/`rready` behave as in the state the timeout interrupted. AR is completed first if still pending, then R is accepted.
  - The R beat is discarded with no second `o_done`. Then go to IDLE.
- Triggers arriving while `o_busy`=1 are ignored, with no queueing. The upstream accesser must wait for `o_done`.
- No AXI handshake is ever abandoned: `arvalid` is never deasserted before `arready`.

## Timing

- Reset values:
  - `o_mem_value`=0, `o_done`=0, `o_error`=0, `o_busy`=0.
  - `m_axi_arvalid`=0, `m_axi_rready`=0, `m_axi_araddr`=0.
  - State IDLE, timeout counter 0.
- Trigger sampled at edge T:
  - `arvalid`=1 from T+1.
  - With a zero-wait slave (`arready`=1 at T+1 and `rvalid`=1 at T+2), `o_done` is high during cycle T+3.
  - Minimum latency is therefore 3 cycles.
- `o_done`/`o_error` are registered, high for exactly one cycle, and coincide with `o_busy` dropping to 0.
- A new trigger is accepted in the same cycle `o_done` is high.
- `rvalid` seen in ADDR before the AR handshake is not accepted, because `rready`=0 in ADDR.
- Reset asserted mid-transaction returns the block to IDLE on the next edge with all outputs at reset values. The interconnect is reset in the same domain.

## Configuration

- Macro: `LOG_AXI_READER_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter increments each cycle in ADDR or DATA.
  - When the count reaches `TIMEOUT_CYCLES` without an R handshake: pulse `o_done`+`o_error`, set `o_mem_value`=0, go to DRAIN with `o_busy` still 1.
  - An R handshake in the same cycle as expiry wins: normal completion, no timeout.
- **Undefined:**
  - No counter and no DRAIN state.
  - The block waits indefinitely in ADDR/DATA.

## Test plan

- Zero-wait slave, `LOG_BASE_ADDR`=32'h4000_0000, trigger with `i_mem_addr`=4:
  - `araddr`=32'h4000_0010.
  - `rdata`=32'h0000_00FF, `rresp`=0 → `o_done` at T+3, `o_mem_value`=32'h0000_00FF, `o_error`=0.
- `arready` delayed 5 cycles, `rvalid` delayed 3 cycles, `i_mem_addr`=8:
  - `araddr`/`arvalid` stable throughout.
  - `o_done` exactly once, `o_busy` high until completion.
- `rresp`=2'b10 with `rdata`=32'hDEAD_BEEF → `o_done`=`o_error`=1, `o_mem_value`=0. Repeat with 2'b11, same result.
- Second trigger during DATA, `i_mem_addr`=5 → ignored. Only one AR issued; the next trigger after `o_done` produces `araddr`=base+0x14.
- Timeout build, `TIMEOUT_CYCLES`=16, `arready` held low 40 cycles:
  - `o_done`+`o_error` 16 cycles after AR issue.
  - `arvalid` stays high; the later R beat is discarded, `o_busy` falls after it.
  - No second `o_done`.
- `rst` asserted during DATA → next cycle `arvalid`=`rready`=0, `o_busy`=0, no `o_done`. A fresh trigger then completes normally.
